iter_counter: RTL and testbench

Parametrised iteration counter for the multiplier datapath's control unit. It generalises the fixed 4-bit Load/K counter:
- configurable width;
- run-time up/down direction;
- hold or auto-reload on terminal count;
- clock enable;
- explicit one-cycle Done pulse and Busy status.

The multiplier FSM loads the iteration count, steps it once per shift-add cycle, and ends the operation on K/Done.

---
 rtl/iter_counter_pkg.sv | 14 +
 rtl/iter_step.sv | 21 ++
 rtl/iter_counter.sv | 81 ++++++++
 tb/tb_iter_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/iter_counter_pkg.sv
// Shared multiplier-control definitions: counter state encoding and direction constants.
// Pure declarations: no logic, no latency, no flow control.
package iter_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/iter_step.sv
// Combinational count stepper: next count in the chosen direction plus terminal match.
// Zero latency; no flow control (pure function of count and direction).
module iter_step
  import iter_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  output logic [WIDTH-1:0] next_count,
  output logic             at_term
);

  logic [WIDTH-1:0] term_val;

  // Up runs to all-ones, down runs to zero; arithmetic wraps modulo 2^WIDTH.
  assign term_val   = (dir == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign next_count = (dir == DIR_UP) ? count + 1'b1 : count - 1'b1;
  assign at_term    = (count == term_val);

endmodule

// File: rtl/iter_counter.sv
// Loadable up/down iteration counter with hold-or-reload at terminal and a one-cycle done pulse.
// Count visible one cycle after load; done one cycle after the completing step; en stalls, never backpressures.
module iter_counter
  import iter_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             k,
  output logic             done,
  output logic             busy
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt, reload, reload_nxt, step_count;
  logic             dir, dir_nxt, done_nxt, at_term;

  iter_step #(.WIDTH(WIDTH)) u_step (
    .count      (count),
    .dir        (dir),
    .next_count (step_count),
    .at_term    (at_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      dir    <= DIR_DOWN;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      dir    <= dir_nxt;
      reload <= reload_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    dir_nxt    = dir;
    reload_nxt = reload;
    done_nxt   = 1'b0;
    if (load) begin
      // A load restarts from any state; an aborted run never reports done.
      state_nxt  = RUN;
      count_nxt  = load_val;
      dir_nxt    = up;
      reload_nxt = load_val;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (at_term) begin
              done_nxt = 1'b1;
              if (AUTO_RELOAD != 0) count_nxt = reload;
              else                  state_nxt = DONE;
            end else begin
              count_nxt = step_count;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign k    = (state != IDLE) && at_term;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_iter_counter.sv
// Randomized bench for iter_counter: hold and auto-reload instances against a step-count reference model.
module tb_iter_counter;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1, load = 1'b0, up = 1'b0, en = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count0, count1;
  logic         k0, k1, done0, done1, busy0, busy1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference: a run is a start value, a direction and a number of steps taken.
  int mstart [2];
  int msteps [2];
  bit mup    [2];
  int mphase [2];  // 0 idle, 1 running, 2 finished
  bit mdone  [2];

  always #5 clk = ~clk;

  iter_counter #(.WIDTH(W), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .up(up), .en(en),
    .count(count0), .k(k0), .done(done0), .busy(busy0)
  );

  iter_counter #(.WIDTH(W), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .up(up), .en(en),
    .count(count1), .k(k1), .done(done1), .busy(busy1)
  );

  function automatic int m_dist(int i);
    return mup[i] ? (MAXV - mstart[i]) : mstart[i];
  endfunction

  function automatic int m_count(int i);
    if (mphase[i] == 0) return 0;
    return mup[i] ? (mstart[i] + msteps[i]) : (mstart[i] - msteps[i]);
  endfunction

  function automatic int m_k(int i);
    return (mphase[i] != 0 && msteps[i] == m_dist(i)) ? 1 : 0;
  endfunction

  task automatic model_step(bit r, bit l, int lv, bit u, bit e);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mphase[i] = 0; mstart[i] = 0; msteps[i] = 0; mup[i] = 1'b0; mdone[i] = 1'b0;
      end else if (l) begin
        mphase[i] = 1; mstart[i] = lv; msteps[i] = 0; mup[i] = u; mdone[i] = 1'b0;
      end else if (mphase[i] == 1 && e) begin
        if (msteps[i] == m_dist(i)) begin
          mdone[i] = 1'b1;
          if (i == 1) msteps[i] = 0;
          else        mphase[i] = 2;
        end else begin
          msteps[i] = msteps[i] + 1;
          mdone[i] = 1'b0;
        end
      end else begin
        mdone[i] = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(bit r, bit l, int lv, bit u, bit e);
    reset = r; load = l; load_val = W'(lv); up = u; en = e;
    @(posedge clk);
    #1;
    model_step(r, l, lv, u, e);
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("c0.count", 32'(count0), m_count(0));
      check("c0.k",     32'(k0),     m_k(0));
      check("c0.done",  32'(done0),  32'(mdone[0]));
      check("c0.busy",  32'(busy0),  (mphase[0] == 1) ? 1 : 0);
      check("c1.count", 32'(count1), m_count(1));
      check("c1.k",     32'(k1),     m_k(1));
      check("c1.done",  32'(done1),  32'(mdone[1]));
      check("c1.busy",  32'(busy1),  (mphase[1] == 1) ? 1 : 0);
    end
  end

  initial begin
    int exp_rl [8] = '{1, 0, 2, 1, 0, 2, 1, 0};
    bit r, l, u, e;
    int lv;

    // Reset held with en high, then idle with en.
    apply(1, 0, 0, 0, 1);
    apply(1, 0, 0, 0, 1);
    check("lit.rst.count", 32'(count0), 0);
    check("lit.rst.busy",  32'(busy0), 0);
    apply(0, 0, 0, 0, 1);
    check("lit.idle.count", 32'(count0), 0);
    check("lit.idle.k",     32'(k0), 0);
    check("lit.idle.done",  32'(done0), 0);

    // Down from 3.
    apply(0, 1, 3, 0, 1);
    check("lit.dn.load", 32'(count0), 3);
    check("lit.dn.busy", 32'(busy0), 1);
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    check("lit.dn.zero", 32'(count0), 0);
    check("lit.dn.k",    32'(k0), 1);
    check("lit.dn.nodone", 32'(done0), 0);
    apply(0, 0, 0, 0, 1);
    check("lit.dn.done",  32'(done0), 1);
    check("lit.dn.idle",  32'(busy0), 0);
    check("lit.dn.rl",    32'(count1), 3);
    apply(0, 0, 0, 0, 1);
    check("lit.dn.pulse", 32'(done0), 0);
    check("lit.dn.hold",  32'(count0), 0);

    // Up from 13 with en toggling.
    apply(0, 1, 13, 1, 1);
    apply(0, 0, 0, 0, 1);
    check("lit.up.14", 32'(count0), 14);
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1);
    check("lit.up.15", 32'(count0), 15);
    check("lit.up.k",  32'(k0), 1);
    apply(0, 0, 0, 0, 0);
    check("lit.up.wait", 32'(done0), 0);
    apply(0, 0, 0, 0, 1);
    check("lit.up.done", 32'(done0), 1);

    // Auto-reload from 2, continuous en.
    apply(0, 1, 2, 0, 1);
    for (int j = 0; j < 8; j++) begin
      apply(0, 0, 0, 0, 1);
      check("lit.rl.count", 32'(count1), exp_rl[j]);
      check("lit.rl.done",  32'(done1), (exp_rl[j] == 2) ? 1 : 0);
    end

    // Reload mid-run aborts without done.
    apply(0, 1, 5, 0, 1);
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    apply(0, 1, 1, 0, 1);
    check("lit.abort.count", 32'(count0), 1);
    check("lit.abort.done",  32'(done0), 0);
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    check("lit.abort.fin", 32'(done0), 1);

    // Reset coincident with load at count 2.
    apply(0, 1, 4, 0, 1);
    apply(0, 0, 0, 0, 1);
    apply(0, 0, 0, 0, 1);
    apply(1, 1, 9, 1, 1);
    check("lit.rstld.count", 32'(count0), 0);
    check("lit.rstld.busy",  32'(busy1), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 8);
      lv = int'($urandom_range(0, MAXV));
      u  = 1'($urandom_range(0, 1));
      e  = ($urandom_range(0, 3) != 0);
      apply(r, l, lv, u, e);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
